// File: rtl/if_stage_pkg.sv
`timescale 1ns/1ps
// Shared fetch-stage constants and the instruction buffer entry layout.
// Pure definitions: no timing, no flow control.
package if_stage_pkg;

    localparam int          REG_BUS  = 64;
    localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [REG_BUS-1:0] pc;
        logic [31:0]        inst;
    } buf_entry_t;

    function automatic logic [REG_BUS-1:0] align4(input logic [REG_BUS-1:0] pc);
        return {pc[REG_BUS-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_buf.sv
`timescale 1ns/1ps
// DEPTH-entry FIFO of fetched {pc, inst}; head visible one cycle after push.
// No internal backpressure: the fetch stage reserves space before requesting.
module if_buf
    import if_stage_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
)(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  buf_entry_t    i_push_dat,
    input  logic          i_pop,
    input  logic          i_flush,
    output logic [CW-1:0] o_count,
    output buf_entry_t    o_head_dat
);

    buf_entry_t    r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    // Explicit wrap keeps non-power-of-two depths correct.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wptr <= ptr_inc(r_wptr);
            if (i_pop)  r_rptr <= ptr_inc(r_rptr);
            if (i_push && !i_pop)      r_count <= r_count + 1'b1;
            else if (!i_push && i_pop) r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_push && !i_flush) r_mem[r_wptr] <= i_push_dat;
    end

    assign o_count    = r_count;
    assign o_head_dat = r_mem[r_rptr];

endmodule

// File: rtl/if_stage.sv
`timescale 1ns/1ps
// Instruction fetch: issues sequential fetches, buffers in-order responses, squashes on redirect.
// Response reaches inst one cycle after arrival; fetch stalls while outstanding + buffered = DEPTH.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [63:0] RESET_PC = if_stage_pkg::RESET_PC,
    parameter int          DEPTH    = 2
)(
    input  logic        clk,
    input  logic        rst,
    output logic        inst_req_valid,
    output logic [63:0] inst_req_addr,
    input  logic        inst_req_ready,
    input  logic        inst_rsp_valid,
    input  logic [31:0] inst_rsp_data,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    input  logic        id_ready,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [63:0] inst_pc
);

    localparam int          CW      = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    logic [63:0]   r_fpc;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_discard;

    logic [CW-1:0] w_buf_count;
    buf_entry_t    w_head;
    buf_entry_t    w_push_dat;
    logic          w_req_hs;
    logic          w_rsp;
    logic          w_push;
    logic          w_pop;
    logic [63:0]   w_rsp_pc;
    logic [CW-1:0] w_out_nxt;
    logic [CW-1:0] w_disc_nxt;
    logic          w_unused;

    assign w_unused = ^redirect_pc[1:0];

    assign inst_req_valid = rst && !redirect_valid
                         && (({1'b0, r_outstanding} + {1'b0, w_buf_count}) < DEPTH_C);
    assign inst_req_addr  = r_fpc;
    assign w_req_hs       = inst_req_valid && inst_req_ready;

    // Responses with nothing outstanding are strays from before a reset.
    assign w_rsp  = inst_rsp_valid && (r_outstanding != '0);
    assign w_push = w_rsp && !redirect_valid && (r_discard == '0);
    assign w_pop  = (w_buf_count != '0) && id_ready && !redirect_valid;

    // With no discards pending, outstanding requests are contiguous and end just below fpc.
    assign w_rsp_pc   = r_fpc - 64'({r_outstanding, 2'b00});
    assign w_push_dat = '{pc: w_rsp_pc, inst: inst_rsp_data};

    always_comb begin
        w_out_nxt = r_outstanding;
        if (w_req_hs && !w_rsp)      w_out_nxt = r_outstanding + 1'b1;
        else if (!w_req_hs && w_rsp) w_out_nxt = r_outstanding - 1'b1;
    end

    always_comb begin
        w_disc_nxt = r_discard;
        if (redirect_valid)                  w_disc_nxt = w_rsp ? r_outstanding - 1'b1 : r_outstanding;
        else if (w_rsp && r_discard != '0)   w_disc_nxt = r_discard - 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fpc         <= align4(RESET_PC);
            r_outstanding <= '0;
            r_discard     <= '0;
        end else begin
            r_outstanding <= w_out_nxt;
            r_discard     <= w_disc_nxt;
            if (redirect_valid) r_fpc <= align4(redirect_pc);
            else if (w_req_hs)  r_fpc <= r_fpc + 64'd4;
        end
    end

    if_buf #(.DEPTH(DEPTH)) u_buf (
        .clk        (clk),
        .rst_n      (rst),
        .i_push     (w_push),
        .i_push_dat (w_push_dat),
        .i_pop      (w_pop),
        .i_flush    (redirect_valid),
        .o_count    (w_buf_count),
        .o_head_dat (w_head)
    );

    assign inst_valid = (w_buf_count != '0);
    assign inst       = inst_valid ? w_head.inst : NOP_INST;
    assign inst_pc    = inst_valid ? w_head.pc   : 64'd0;

endmodule

// File: tb/tb_if_stage.sv
`timescale 1ns/1ps
// Randomized bench for if_stage: bus responder plus a stream-level scoreboard.
module tb_if_stage;
    import if_stage_pkg::*;

    localparam logic [63:0] RPC = 64'h0000_0000_8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        inst_req_valid;
    logic [63:0] inst_req_addr;
    logic        inst_req_ready = 1'b0;
    logic        inst_rsp_valid = 1'b0;
    logic [31:0] inst_rsp_data  = '0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc    = '0;
    logic        id_ready       = 1'b0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [63:0] inst_pc;

    always #5 clk = ~clk;

    if_stage #(.RESET_PC(RPC), .DEPTH(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .inst_req_valid (inst_req_valid),
        .inst_req_addr  (inst_req_addr),
        .inst_req_ready (inst_req_ready),
        .inst_rsp_valid (inst_rsp_valid),
        .inst_rsp_data  (inst_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_ready       (id_ready),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc)
    );

    typedef struct { logic [63:0] addr; int epoch; int due; } pend_t;
    typedef struct { logic [63:0] pc; logic [31:0] inst; } exp_t;

    pend_t       pend[$];
    exp_t        exp_q[$];
    logic [63:0] exp_next;
    int epoch = 0, rsp_epoch = -1, cyc = 0;
    int ready_pct = 100, idr_pct = 100, redir_permil = 0, rsp_pct = 100, lat_min = 0, lat_max = 0;
    int n_checks = 0, n_pass = 0;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ {a[47:32], a[63:48]} ^ 32'h3C5A_0F17;
    endfunction

    function automatic logic [63:0] rand_target();
        logic [63:0] t;
        case ($urandom_range(3))
            0:       t = RPC + 64'($urandom_range(255));
            1:       t = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(15));
            default: t = {$urandom, $urandom};
        endcase
        return t;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    endtask

    // Expected decode stream: contiguous words from the last redirect/reset target.
    task automatic reload_exp(input logic [63:0] tgt);
        exp_q.delete();
        exp_next = {tgt[63:2], 2'b00};
    endtask

    task automatic refill();
        while (exp_q.size() < 8) begin
            exp_q.push_back('{exp_next, mem_word(exp_next)});
            exp_next += 64'd4;
        end
    endtask

    // Called just after a falling edge: drive this cycle's inputs, then record any request accept.
    task automatic drive_cycle(input bit force_redir, input logic [63:0] tgt);
        cyc++;
        inst_req_ready = ($urandom_range(99) < ready_pct);
        id_ready       = ($urandom_range(99) < idr_pct);
        redirect_valid = force_redir || ($urandom_range(999) < redir_permil);
        redirect_pc    = force_redir ? tgt : rand_target();
        inst_rsp_valid = 1'b0;
        inst_rsp_data  = $urandom;
        rsp_epoch      = -1;
        if (pend.size() != 0 && pend[0].due <= cyc && $urandom_range(99) < rsp_pct) begin
            inst_rsp_valid = 1'b1;
            inst_rsp_data  = mem_word(pend[0].addr);
            rsp_epoch      = pend[0].epoch;
            void'(pend.pop_front());
        end
        if (redirect_valid) begin
            epoch++;
            reload_exp(redirect_pc);
        end
        refill();
        #1;
        if (inst_req_valid && inst_req_ready)
            pend.push_back('{inst_req_addr, epoch, cyc + 1 + int'($urandom_range(lat_max, lat_min))});
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b0;
        inst_req_ready = 1'b0;
        id_ready       = 1'b0;
        redirect_valid = 1'b0;
        inst_rsp_valid = 1'b0;
        pend.delete();
        epoch++;
        reload_exp(RPC);
        refill();
        repeat (n - 1) begin
            @(negedge clk);
            cyc++;
        end
        @(negedge clk);
        rst = 1'b1;
        drive_cycle(1'b0, '0);
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(negedge clk);
            drive_cycle(1'b0, '0);
        end
    endtask

    // Monitor: model of occupancy (outstanding + buffered) and the fetch/decode streams.
    initial begin : monitor
        int          m_out, m_buf;
        logic [63:0] m_fetch;
        bit          exp_rv, m_vld, hs, pop, push, rsp;
        exp_t        e;
        m_out   = 0;
        m_buf   = 0;
        m_fetch = RPC;
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                check("rst_req_valid",  64'(inst_req_valid), 64'd0);
                check("rst_inst_valid", 64'(inst_valid), 64'd0);
                check("rst_inst",       64'(inst), 64'(NOP_INST));
                check("rst_inst_pc",    inst_pc, 64'd0);
                check("rst_req_addr",   inst_req_addr, RPC);
                m_out   = 0;
                m_buf   = 0;
                m_fetch = RPC;
            end else begin
                m_vld  = (m_buf != 0);
                exp_rv = (m_out + m_buf < 2) && !redirect_valid;
                check("req_valid",  64'(inst_req_valid), 64'(exp_rv));
                check("inst_valid", 64'(inst_valid), 64'(m_vld));
                if (!m_vld) begin
                    check("idle_inst",    64'(inst), 64'(NOP_INST));
                    check("idle_inst_pc", inst_pc, 64'd0);
                end
                hs = exp_rv && inst_req_ready;
                if (hs) begin
                    check("req_addr", inst_req_addr, m_fetch);
                    m_fetch += 64'd4;
                end
                pop = m_vld && id_ready && !redirect_valid;
                if (pop) begin
                    check("exp_avail", 64'(exp_q.size() != 0), 64'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("inst_pc", inst_pc, e.pc);
                        check("inst",    64'(inst), 64'(e.inst));
                    end
                end
                rsp  = inst_rsp_valid;
                push = rsp && !redirect_valid && (rsp_epoch == epoch);
                if (redirect_valid) begin
                    m_buf   = 0;
                    m_fetch = {redirect_pc[63:2], 2'b00};
                end else begin
                    m_buf = m_buf + int'(push) - int'(pop);
                end
                m_out = m_out + int'(hs) - int'(rsp);
            end
        end
    end

    initial begin : stimulus
        int w;
        do_reset(3);
        // Streaming with a one-cycle memory.
        run(12);
        // Decode stalled: fetch must stop at two in flight; head must hold.
        idr_pct = 0;
        run(12);
        idr_pct = 100;
        run(6);
        // Redirect with two late responses in flight.
        lat_min = 6;
        lat_max = 6;
        w = 0;
        while (pend.size() != 2 && w < 20) begin
            @(negedge clk);
            drive_cycle(1'b0, '0);
            w++;
        end
        check("two_outstanding", 64'(pend.size()), 64'd2);
        @(negedge clk);
        drive_cycle(1'b1, 64'h0000_0000_8000_0103);
        run(20);
        // Redirect colliding with a response and a pop.
        lat_min = 0;
        lat_max = 0;
        run(6);
        @(negedge clk);
        drive_cycle(1'b1, 64'h0000_0000_0000_1234);
        run(6);
        // Reset while requests are in flight and decode is stalled.
        lat_min = 2;
        lat_max = 2;
        idr_pct = 0;
        run(4);
        do_reset(2);
        idr_pct = 100;
        run(10);
        // fpc wrap across 2^64.
        lat_min = 0;
        lat_max = 1;
        @(negedge clk);
        drive_cycle(1'b1, 64'hFFFF_FFFF_FFFF_FFF6);
        run(20);
        // Random stress.
        ready_pct    = 70;
        idr_pct      = 60;
        redir_permil = 20;
        rsp_pct      = 70;
        lat_min      = 0;
        lat_max      = 3;
        for (int i = 0; i < 10000; i++) begin
            if (i % 2500 == 1249) do_reset(2);
            else run(1);
        end
        @(negedge clk);
        #4;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
